cpu_bus_arb: RTL and testbench

Single-outstanding arbiter between the CPU's instruction-fetch and data-memory request ports and one shared SRAM-like external bus. Sits directly downstream of the address-mapping stage: it consumes the already-translated physical addresses for both ports, serialises requests, generates write strobes and returns read data with a one-cycle handshake pulse. Data requests win ties; an instruction request waiting behind a data access is granted next.

---
 rtl/cpu_bus_arb_pkg.sv | 28 ++
 rtl/cpu_bus_arb_bus_wstrb_gen.sv | 25 ++
 rtl/cpu_bus_arb.sv | 140 ++++++++++++++
 tb/tb_cpu_bus_arb.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_arb_pkg.sv
// Shared types for the CPU bus arbiter: FSM states, owner codes, size codes
// and the latched bus command.
package cpu_bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_cmd_t;

endpackage

// File: rtl/cpu_bus_arb_bus_wstrb_gen.sv
// Byte-lane write strobes from access size and low address bits.
// Reads and the unused size code produce no strobes.
module bus_wstrb_gen
  import cpu_bus_arb_pkg::*;
(
  input  logic       i_wr,
  input  logic [1:0] i_size,
  input  logic [1:0] i_addr_lo,
  output logic [3:0] o_wstrb
);

  always_comb begin
    o_wstrb = 4'b0000;
    if (i_wr) begin
      case (i_size)
        SIZE_B:  o_wstrb = 4'b0001 << i_addr_lo;
        // Halves only look at addr[1]; a misaligned addr[0] is ignored.
        SIZE_H:  o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        SIZE_W:  o_wstrb = 4'b1111;
        default: o_wstrb = 4'b0000;
      endcase
    end
  end

endmodule

// File: rtl/cpu_bus_arb.sv
// Single-outstanding arbiter between instruction-fetch and data ports onto
// one SRAM-like bus. Data wins ties unless it owned the previous grant.
module cpu_bus_arb
  import cpu_bus_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  dbg_state
);

  arb_state_t  r_state;
  owner_t      r_owner;
  owner_t      r_last_owner;
  logic        r_inst_data_ok;
  logic        r_data_data_ok;
  logic [31:0] r_inst_rdata;
  logic [31:0] r_data_rdata;
  logic        r_bus_req;
  logic        r_bus_wr;
  logic [1:0]  r_bus_size;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_wstrb;

  logic        w_grant_data;
  logic        w_grant_inst;
  logic        w_idle;
  bus_cmd_t    w_cmd;
  logic [3:0]  w_wstrb;

  // The previous owner breaks ties so a waiting fetch is served next.
  assign w_grant_data = data_req && (!inst_req || (r_last_owner == OWN_INST));
  assign w_grant_inst = inst_req && !w_grant_data;
  assign w_idle       = (r_state == ST_IDLE) && !rst;

  assign inst_addr_ok = w_idle && w_grant_inst;
  assign data_addr_ok = w_idle && w_grant_data;

  assign w_cmd = w_grant_data ? '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata}
                              : '{wr: 1'b0, size: SIZE_W, addr: inst_addr, wdata: 32'h0};

  bus_wstrb_gen u_wstrb_gen (
    .i_wr      (w_cmd.wr),
    .i_size    (w_cmd.size),
    .i_addr_lo (w_cmd.addr[1:0]),
    .o_wstrb   (w_wstrb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_owner        <= OWN_INST;
      r_last_owner   <= OWN_INST;
      r_inst_data_ok <= 1'b0;
      r_data_data_ok <= 1'b0;
      r_inst_rdata   <= 32'h0;
      r_data_rdata   <= 32'h0;
      r_bus_req      <= 1'b0;
      r_bus_wr       <= 1'b0;
      r_bus_size     <= 2'd0;
      r_bus_addr     <= 32'h0;
      r_bus_wdata    <= 32'h0;
      r_bus_wstrb    <= 4'b0000;
    end else begin
      r_inst_data_ok <= 1'b0;
      r_data_data_ok <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_data || w_grant_inst) begin
            r_owner      <= w_grant_data ? OWN_DATA : OWN_INST;
            r_last_owner <= w_grant_data ? OWN_DATA : OWN_INST;
            r_bus_req    <= 1'b1;
            r_bus_wr     <= w_cmd.wr;
            r_bus_size   <= w_cmd.size;
            r_bus_addr   <= w_cmd.addr;
            r_bus_wdata  <= w_cmd.wdata;
            r_bus_wstrb  <= w_wstrb;
            r_state      <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (bus_addr_ok) begin
            r_bus_req <= 1'b0;
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Stores also complete here; the captured word lands on the owner's port.
          if (bus_data_ok) begin
            if (r_owner == OWN_DATA) begin
              r_data_rdata   <= bus_rdata;
              r_data_data_ok <= 1'b1;
            end else begin
              r_inst_rdata   <= bus_rdata;
              r_inst_data_ok <= 1'b1;
            end
            r_state <= ST_RESP;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign inst_data_ok = r_inst_data_ok;
  assign inst_rdata   = r_inst_rdata;
  assign data_data_ok = r_data_data_ok;
  assign data_rdata   = r_data_rdata;
  assign bus_req      = r_bus_req;
  assign bus_wr       = r_bus_wr;
  assign bus_size     = r_bus_size;
  assign bus_addr     = r_bus_addr;
  assign bus_wdata    = r_bus_wdata;
  assign bus_wstrb    = r_bus_wstrb;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_cpu_bus_arb.sv
// Directed bench for cpu_bus_arb: a bus responder with configurable stalls,
// queued expected bus commands and responses, and explicit timing checks.
`timescale 1ns/1ps
module tb_cpu_bus_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;
  logic [1:0]  dbg_state;

  cpu_bus_arb dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_size     (bus_size),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_wstrb    (bus_wstrb),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok),
    .bus_rdata    (bus_rdata),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [70:0] bus_q[$];   // {wr, size, addr, wdata (0 on reads), wstrb}
  logic [31:0] rd_q[$];    // read data the responder returns, in order
  logic [32:0] exp_q[$];   // {owner is data, rdata}
  logic [31:0] mdl_inst_rdata = 32'h0;
  logic [31:0] mdl_data_rdata = 32'h0;
  int          addr_wait = 0;
  int          data_wait = 0;
  bit          spur = 1'b0;
  int          rsp_phase = 0;
  int          rsp_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_resp"}, {inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata}, 128'h0);
    chk({tag, "_bus"}, {bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb}, 128'h0);
    chk({tag, "_state"}, dbg_state, 128'h0);
  endtask

  // ---------------- bus responder + response monitor ----------------
  initial begin
    logic [32:0] e;
    logic [70:0] b;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (inst_data_ok || data_data_ok) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          chk("resp_owner", {inst_data_ok, data_data_ok}, e[32] ? 2'b01 : 2'b10);
          chk("resp_rdata", e[32] ? data_rdata : inst_rdata, e[31:0]);
          if (e[32]) mdl_data_rdata = e[31:0];
          else       mdl_inst_rdata = e[31:0];
        end
      end
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      if (rst) begin
        rsp_phase = 0;
        rsp_cnt   = 0;
      end else if (rsp_phase == 0) begin
        if (bus_req) begin
          if (bus_q.size() == 0) begin
            chk("unexpected_bus_req", bus_req, 1'b0);
          end else begin
            b = bus_q[0];
            chk("bus_fields", {bus_wr, bus_size, bus_addr, (b[70] ? bus_wdata : 32'h0), bus_wstrb}, b);
            if (rsp_cnt >= addr_wait) begin
              bus_addr_ok = 1'b1;
              void'(bus_q.pop_front());
              rsp_phase = 1;
              rsp_cnt   = 0;
            end else begin
              rsp_cnt++;
              if (spur) begin
                bus_data_ok = 1'b1;
                bus_rdata   = 32'hDEADBEEF;
              end
            end
          end
        end else if (spur) begin
          bus_data_ok = 1'b1;
          bus_rdata   = 32'hDEADBEEF;
        end
      end else begin
        if (rsp_cnt >= data_wait) begin
          bus_data_ok = 1'b1;
          bus_rdata   = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hBADBAD00;
          rsp_phase   = 0;
          rsp_cnt     = 0;
        end else begin
          rsp_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_txn(input bit own_data, input bit wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic [3:0] strb);
    bus_q.push_back({wr, size, addr, (wr ? wdata : 32'h0), strb});
    rd_q.push_back(rdata);
    exp_q.push_back({own_data, rdata});
  endtask

  task automatic issue(input bit own_data, input bit wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata, output int lat);
    @(negedge clk);
    if (own_data) begin
      data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wdata;
    end else begin
      inst_req = 1'b1; inst_addr = addr;
    end
    #2;
    lat = 0;
    while (!(own_data ? data_addr_ok : inst_addr_ok) && lat < 50) begin
      @(negedge clk);
      #2;
      lat++;
    end
    chk(own_data ? "data_grant" : "inst_grant", lat < 50, 1'b1);
    @(negedge clk);
    if (own_data) data_req = 1'b0;
    else          inst_req = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic run_txn(input bit own_data, input bit wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic [3:0] strb);
    int lat;
    push_txn(own_data, wr, size, addr, wdata, rdata, strb);
    issue(own_data, wr, size, addr, wdata, lat);
    wait_drain();
  endtask

  task automatic do_reset(input bit hold_reqs);
    @(negedge clk);
    rst = 1'b1;
    inst_req = hold_reqs;
    data_req = hold_reqs;
    #2;
    chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    bus_q.delete();
    rd_q.delete();
    exp_q.delete();
    mdl_inst_rdata = 32'h0;
    mdl_data_rdata = 32'h0;
    rst = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int n;
    int cnt;
    bit seen;
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h0; data_wdata = 32'h0;

    // Reset state
    @(negedge clk);
    #2;
    chk_zero("init");
    @(negedge clk);
    rst = 1'b0;

    // Single zero-wait fetch: grant N, bus_req N+1, capture N+2, data_ok N+3
    push_txn(1'b0, 1'b0, 2'd2, 32'h1FC00000, 32'h0, 32'h3C08BFC0, 4'b0000);
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h1FC00000;
    #2;
    chk("fetch_addr_ok_N", {inst_addr_ok, data_addr_ok}, 2'b10);
    @(negedge clk);
    inst_req = 1'b0;
    #2;
    chk("fetch_bus_req_N1", {bus_req, dbg_state}, {1'b1, 2'd1});
    @(negedge clk);
    #2;
    chk("fetch_wait_N2", {bus_req, inst_data_ok, dbg_state}, {1'b0, 1'b0, 2'd2});
    @(negedge clk);
    #2;
    chk("fetch_data_ok_N3", {inst_data_ok, data_data_ok, inst_rdata, dbg_state}, {1'b1, 1'b0, 32'h3C08BFC0, 2'd3});
    @(negedge clk);
    #2;
    chk("fetch_data_ok_pulse", {inst_data_ok, dbg_state}, {1'b0, 2'd0});
    wait_drain();

    // Write strobes for byte/half/word stores, none on loads
    run_txn(1'b1, 1'b1, 2'd0, 32'h00001003, 32'hAAAAAAAA, 32'h11111111, 4'b1000);
    run_txn(1'b1, 1'b1, 2'd1, 32'h00001002, 32'hBBBBBBBB, 32'h22222222, 4'b1100);
    run_txn(1'b1, 1'b1, 2'd2, 32'h00001000, 32'h12345678, 32'h33333333, 4'b1111);
    run_txn(1'b1, 1'b1, 2'd0, 32'h00001001, 32'hCCCCCCCC, 32'h44444444, 4'b0010);
    run_txn(1'b1, 1'b1, 2'd1, 32'h00001000, 32'hDDDDDDDD, 32'h55555555, 4'b0011);
    run_txn(1'b1, 1'b1, 2'd3, 32'h00001000, 32'hEEEEEEEE, 32'h66666666, 4'b0000);
    run_txn(1'b1, 1'b0, 2'd2, 32'h00001000, 32'hFFFFFFFF, 32'hCAFEF00D, 4'b0000);
    run_txn(1'b1, 1'b0, 2'd0, 32'h00001001, 32'h0,        32'h0000AB00, 4'b0000);

    // Both requests held from reset: DATA, INST, DATA, INST, one grant per 4 cycles
    inst_addr = 32'h1FC00004;
    data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h00002000; data_wdata = 32'h0;
    do_reset(1'b1);
    push_txn(1'b1, 1'b0, 2'd2, 32'h00002000, 32'h0, 32'hA1A1A1A1, 4'b0000);
    push_txn(1'b0, 1'b0, 2'd2, 32'h1FC00004, 32'h0, 32'hB1B1B1B1, 4'b0000);
    push_txn(1'b1, 1'b0, 2'd2, 32'h00002000, 32'h0, 32'hA2A2A2A2, 4'b0000);
    push_txn(1'b0, 1'b0, 2'd2, 32'h1FC00004, 32'h0, 32'hB2B2B2B2, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      lat = 0;
      #2;
      while (!(inst_addr_ok || data_addr_ok) && lat < 20) begin
        @(negedge clk);
        #2;
        lat++;
      end
      chk("alt_grant_owner", {data_addr_ok, inst_addr_ok}, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("alt_grant_gap", lat, (k == 0) ? 0 : 3);
      @(negedge clk);
      if (k == 3) begin
        inst_req = 1'b0;
        data_req = 1'b0;
      end
    end
    wait_drain();

    // Bus stalls: addr_ok held off 5 cycles, data_ok held off 3; fetch waits behind
    addr_wait = 5;
    data_wait = 3;
    push_txn(1'b1, 1'b1, 2'd2, 32'h00003000, 32'h55AA55AA, 32'h00005A5A, 4'b1111);
    push_txn(1'b0, 1'b0, 2'd2, 32'h1FC00008, 32'h0, 32'h0BADC0DE, 4'b0000);
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h00003000; data_wdata = 32'h55AA55AA;
    #2;
    chk("stall_data_grant", {data_addr_ok, inst_addr_ok}, 2'b10);
    @(negedge clk);
    data_req = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h1FC00008;
    n = 0;
    seen = 1'b0;
    #2;
    while (!inst_addr_ok && n < 40) begin
      if (data_data_ok) seen = 1'b1;
      @(negedge clk);
      #2;
      n++;
    end
    chk("stall_fetch_after_resp", {seen, n}, {1'b1, 32'd11});
    @(negedge clk);
    inst_req = 1'b0;
    addr_wait = 0;
    data_wait = 0;
    wait_drain();

    // Spurious bus_data_ok in IDLE and ADDR is ignored
    spur = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("spur_idle_rdata", {inst_rdata, data_rdata}, {mdl_inst_rdata, mdl_data_rdata});
    chk("spur_idle_state", {dbg_state, inst_data_ok, data_data_ok}, 4'b0000);
    addr_wait = 3;
    run_txn(1'b0, 1'b0, 2'd2, 32'h1FC0000C, 32'h0, 32'h24080001, 4'b0000);
    spur = 1'b0;
    addr_wait = 0;
    #2;
    chk("spur_after_rdata", {inst_rdata, data_rdata}, {32'h24080001, 32'h00005A5A});

    // Reset while a store sits in WAIT: abandoned, then normal service resumes
    data_wait = 10;
    push_txn(1'b1, 1'b1, 2'd2, 32'h00004000, 32'h01020304, 32'h00000077, 4'b1111);
    issue(1'b1, 1'b1, 2'd2, 32'h00004000, 32'h01020304, lat);
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("rst_test_in_wait", dbg_state, 2'd2);
    do_reset(1'b0);
    data_wait = 0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      #2;
      if (data_data_ok || inst_data_ok) cnt++;
    end
    chk("rst_abandoned_no_data_ok", cnt, 0);
    run_txn(1'b1, 1'b0, 2'd2, 32'h00004000, 32'h0, 32'h600DF00D, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
